// File: rtl/rf_ctrl_pkg.sv
// Shared constants, request record and helpers for the register-file writeback path.
// Used by rf_wb_arbiter and rr_arbiter.
package rf_ctrl_pkg;

  localparam int REG_COUNT  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N      = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_N-1:0]      data;
  } wb_req_t;

  // Position of the set bit in a one-hot vector of up to four requesters; zero when empty.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner, and the pointer
// moves to the winner whenever the grant is taken (accept_i).
module rr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_i,
  input  logic             accept_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;

  // The outer loop walks the priority distance, so the first hit is the nearest requester after ptr.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_i[i] && (i == (int'(ptr_q) + off) % NREQ)) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign grant_idx_o = IDX_W'(onehot_to_idx(4'(grant_o)));

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && found) ptr_d = grant_idx_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters through one-entry buffers.
// Optional macro RF_WB_BYPASS_EN lets a fresh request win arbitration in its accept cycle.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int N      = DEF_N,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*N-1:0]       req_data,
  output logic [ADDR_W-1:0]       writeReg,
  output logic                    regWrite,
  output logic [N-1:0]            data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [REG_COUNT-1:0]    pending
);

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]   buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q [NREQ];
  logic [ADDR_W-1:0] buf_addr_d [NREQ];
  logic [N-1:0]      buf_data_q [NREQ];
  logic [N-1:0]      buf_data_d [NREQ];

  logic              regWrite_q, regWrite_d;
  logic [ADDR_W-1:0] writeReg_q, writeReg_d;
  logic [N-1:0]      data_q, data_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;

  logic [NREQ-1:0]   take, cand, grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [N-1:0]      win_data;

  assign req_ready = ~buf_valid_q;

  // Writes to x0 complete the handshake but never occupy a buffer or the write port.
  always_comb begin
    take = '0;
    for (int i = 0; i < NREQ; i++) begin
      take[i] = req_valid[i] && !buf_valid_q[i] && (req_addr[i*ADDR_W +: ADDR_W] != '0);
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign cand = buf_valid_q | take;
`else
  assign cand = buf_valid_q;
`endif

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst),
    .req_i       (cand),
    .accept_i    (1'b1),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // A granted requester with an empty buffer can only be a bypassed incoming transfer.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        if (buf_valid_q[i]) begin
          win_addr = buf_addr_q[i];
          win_data = buf_data_q[i];
        end else begin
          win_addr = req_addr[i*ADDR_W +: ADDR_W];
          win_data = req_data[i*N +: N];
        end
      end
    end
  end

  always_comb begin
    buf_valid_d = (buf_valid_q & ~grant) | (take & ~grant);
    for (int i = 0; i < NREQ; i++) begin
      buf_addr_d[i] = take[i] ? req_addr[i*ADDR_W +: ADDR_W] : buf_addr_q[i];
      buf_data_d[i] = take[i] ? req_data[i*N +: N] : buf_data_q[i];
    end
    regWrite_d = |grant;
    writeReg_d = (|grant) ? win_addr  : writeReg_q;
    data_d     = (|grant) ? win_data  : data_q;
    grant_id_d = (|grant) ? grant_idx : grant_id_q;
  end

  // Hazard view: every register with a write still buffered, in flight, or bypassing this cycle.
  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (buf_valid_q[i]) pending[buf_addr_q[i]] = 1'b1;
    end
    if (regWrite_q) pending[writeReg_q] = 1'b1;
`ifdef RF_WB_BYPASS_EN
    if (|(grant & ~buf_valid_q)) pending[win_addr] = 1'b1;
`endif
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
      regWrite_q <= 1'b0;
      writeReg_q <= '0;
      data_q     <= '0;
      grant_id_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      data_q      <= data_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign regWrite = regWrite_q;
  assign writeReg = writeReg_q;
  assign data     = data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic against
// a queue-free behavioural model of buffers, round-robin order and pending registers.
module tb_rf_wb_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      reqValid = '0;
  logic [NREQ-1:0]      reqReady;
  logic [NREQ*AW-1:0]   reqAddr = '0;
  logic [NREQ*DW-1:0]   reqData = '0;
  logic [AW-1:0]        writeReg;
  logic                 regWrite;
  logic [DW-1:0]        data;
  logic [0:0]           grantId;
  logic [31:0]          pending;

  rf_wb_arbiter #(.NREQ(NREQ), .N(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_addr  (reqAddr),
    .req_data  (reqData),
    .writeReg  (writeReg),
    .regWrite  (regWrite),
    .data      (data),
    .grant_id  (grantId),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  bit          mBufV [NREQ];
  logic [4:0]  mBufA [NREQ];
  logic [31:0] mBufD [NREQ];
  int          mPtr;
  bit          mWr;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  int          mGid;
  int          winIdx;
  bit          winFromIn;
  logic [4:0]  dutWrites[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NREQ; i++) begin
      mBufV[i] = 1'b0;
      mBufA[i] = '0;
      mBufD[i] = '0;
    end
    mPtr  = NREQ - 1;
    mWr   = 1'b0;
    mAddr = '0;
    mData = '0;
    mGid  = 0;
  endtask

  // Nearest holder of a write after the last winner, searching ptr+1, ptr+2, ... mod NREQ.
  task automatic modelArbitrate();
    winIdx    = -1;
    winFromIn = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int  c;
      bit  incoming;
      c        = (mPtr + k) % NREQ;
      incoming = BYPASS && reqValid[c] && !mBufV[c] && (reqAddr[c*AW +: AW] != 5'd0);
      if (winIdx < 0 && (mBufV[c] || incoming)) begin
        winIdx    = c;
        winFromIn = !mBufV[c];
      end
    end
  endtask

  function automatic logic [31:0] modelPending();
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < NREQ; i++) if (mBufV[i]) p[mBufA[i]] = 1'b1;
    if (mWr) p[mAddr] = 1'b1;
    if (winIdx >= 0 && winFromIn) p[reqAddr[winIdx*AW +: AW]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic modelAdvance();
    bit acc [NREQ];
    for (int i = 0; i < NREQ; i++) acc[i] = reqValid[i] && !mBufV[i] && (reqAddr[i*AW +: AW] != 5'd0);
    if (winIdx >= 0) begin
      mWr  = 1'b1;
      mGid = winIdx;
      mPtr = winIdx;
      if (winFromIn) begin
        mAddr       = reqAddr[winIdx*AW +: AW];
        mData       = reqData[winIdx*DW +: DW];
        acc[winIdx] = 1'b0;
      end else begin
        mAddr         = mBufA[winIdx];
        mData         = mBufD[winIdx];
        mBufV[winIdx] = 1'b0;
      end
    end else begin
      mWr = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        mBufV[i] = 1'b1;
        mBufA[i] = reqAddr[i*AW +: AW];
        mBufD[i] = reqData[i*DW +: DW];
      end
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                               input logic [NREQ*DW-1:0] d);
    reqValid = v;
    reqAddr  = a;
    reqData  = d;
  endtask

  // Called one time unit after a rising edge; returns at the same phase of the next cycle.
  task automatic runCycle(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                          input logic [NREQ*DW-1:0] d);
    logic [NREQ-1:0] expReady;
    applyStimulus(v, a, d);
    #1;
    modelArbitrate();
    for (int i = 0; i < NREQ; i++) expReady[i] = !mBufV[i];
    checkOutput("req_ready", reqReady, expReady);
    checkOutput("pending", pending, modelPending());
    modelAdvance();
    @(posedge clk);
    #1;
    checkOutput("regWrite", regWrite, mWr);
    checkOutput("writeReg", writeReg, mAddr);
    checkOutput("data", data, mData);
    checkOutput("grant_id", grantId, mGid);
    if (regWrite === 1'b1) dutWrites.push_back(writeReg);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) runCycle('0, '0, '0);
  endtask

  function automatic logic [4:0] logAt(input int k);
    return (dutWrites.size() > k) ? dutWrites[k] : 5'h1f;
  endfunction

  initial begin
    int nextAddr;
    modelReset();
    #2;
    checkOutput("rst_regWrite", regWrite, 0);
    checkOutput("rst_writeReg", writeReg, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_grant", grantId, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_ready", reqReady, 2'b11);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // Contention from reset: requester 0 has priority first.
    dutWrites.delete();
    runCycle(2'b11, {5'd7, 5'd3}, {32'h22, 32'h11});
    idleCycles(3);
    checkOutput("pair1_count", dutWrites.size(), 2);
    checkOutput("pair1_first", logAt(0), 3);
    checkOutput("pair1_second", logAt(1), 7);

    // Single write, then a pair that must now start with requester 1.
    dutWrites.delete();
    runCycle(2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF});
    checkOutput("single_e0_regWrite", regWrite, BYPASS);
    checkOutput("single_e0_pending5", pending[5], 1);
    if (!BYPASS) begin
      runCycle('0, '0, '0);
      checkOutput("single_e1_writeReg", writeReg, 5);
      checkOutput("single_e1_data", data, 32'hDEADBEEF);
      checkOutput("single_e1_grant", grantId, 0);
    end
    idleCycles(2);
    checkOutput("single_pending_clear", pending, 0);
    dutWrites.delete();
    runCycle(2'b11, {5'd7, 5'd3}, {32'h44, 32'h33});
    idleCycles(3);
    checkOutput("pair2_first", logAt(0), 7);
    checkOutput("pair2_second", logAt(1), 3);

    // Write to x0 is swallowed.
    dutWrites.delete();
    runCycle(2'b10, {5'd0, 5'd0}, {32'h0000FFFF, 32'd0});
    idleCycles(2);
    checkOutput("x0_no_write", dutWrites.size(), 0);
    checkOutput("x0_pending", pending, 0);

    // One requester streaming addrs 1, 2, 3.
    dutWrites.delete();
    nextAddr = 1;
    for (int c = 0; c < 12 && nextAddr <= 3; c++) begin
      bit willAccept;
      willAccept = !mBufV[0];
      runCycle(2'b01, {5'd0, 5'(nextAddr)}, {32'd0, 32'(100 + nextAddr)});
      if (willAccept) nextAddr++;
    end
    checkOutput("b2b_accepted", nextAddr, 4);
    idleCycles(3);
    checkOutput("b2b_count", dutWrites.size(), 3);
    checkOutput("b2b_order0", logAt(0), 1);
    checkOutput("b2b_order1", logAt(1), 2);
    checkOutput("b2b_order2", logAt(2), 3);

`ifdef RF_WB_BYPASS_EN
    runCycle(2'b10, {5'd9, 5'd0}, {32'hA5A5A5A5, 32'd0});
    checkOutput("byp_regWrite", regWrite, 1);
    checkOutput("byp_writeReg", writeReg, 9);
    checkOutput("byp_ready1", reqReady[1], 1);
    idleCycles(2);
`endif

    // Asynchronous reset with work outstanding.
    runCycle(2'b01, {5'd0, 5'd12}, {32'd0, 32'h12});
    runCycle(2'b11, {5'd14, 5'd13}, {32'h14, 32'h13});
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_regWrite", regWrite, 0);
    checkOutput("arst_pending", pending, 0);
    checkOutput("arst_ready", reqReady, 2'b11);
    modelReset();
    applyStimulus('0, '0, '0);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    dutWrites.delete();
    idleCycles(3);
    checkOutput("arst_no_write", dutWrites.size(), 0);

    // Random traffic against the model.
    for (int c = 0; c < 300; c++) begin
      runCycle(2'($urandom_range(0, 3)),
               {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))},
               {32'($urandom), 32'($urandom)});
    end
    idleCycles(4);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (writeReg / regWrite / data) among NREQ writeback requesters, e.g. ALU writeback and load-unit writeback.
- Each requester has a one-entry holding buffer behind a valid/ready handshake.
- A round-robin arbiter drains the buffers into registered write-port outputs.
- Exports a pending-write bitmap that hazard logic uses to stall readers of in-flight registers.

Parameters:
- NREQ, 2, number of writeback requesters (2..4).
- N, 32, data width; must match register-file width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester buffer can accept.
- req_addr  in  NREQ*ADDR_W  destination register; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*N  write data; requester i uses slice [i*N +: N].
- writeReg  out  ADDR_W  register-file write address (registered).
- regWrite  out  1  register-file write enable (registered).
- data  out  N  register-file write data (registered).
- grant_id  out  $clog2(NREQ)  requester that owns the current write-port beat (registered).
- pending  out  32  bit k = 1 while any buffered or output-stage write targets register k.

Behaviour:
- Reset (rst = 0, asynchronous):
  - all buffers invalid;
  - regWrite = 0, writeReg = 0, data = 0, grant_id = 0;
  - pending = 0;
  - round-robin pointer = NREQ-1, so requester 0 has priority first.
  - A reset asserted mid-operation discards every buffered and output-stage write. No partial write is issued.
- req_ready[i] = !buf_valid[i]. It is a registered-state function and has no combinational dependence on req_valid.
- Accept: req_valid[i] && req_ready[i] at a rising edge.
  - If req_addr = 0, the transfer completes but the write is dropped: the buffer stays empty and no write-port beat is issued.
  - Otherwise {addr, data} is captured and buf_valid[i] is set.
- Arbitration, each cycle, among buffers with buf_valid = 1:
  - Search order is ptr+1, ptr+2, ... modulo NREQ.
  - At the next edge, the winner's {addr, data} loads writeReg/data, regWrite = 1, grant_id = winner, buf_valid[winner] is cleared, and ptr = winner.
  - With no candidate, regWrite = 0 at the next edge; writeReg, data and grant_id hold their values.
- Throughput: one write per cycle in aggregate.
  - A single requester streaming back-to-back gets one write every 2 cycles, because its buffer refills only after draining.
- Latency (macro off): accept edge E0 → output registers load at E1 → register file writes at E2.
- Simultaneous accept and drain on the same buffer cannot occur: ready is low while the buffer is full.
- pending[k] = OR over i of (buf_valid[i] && buf_addr[i] == k), OR (regWrite && writeReg == k). pending[0] is always 0.
- Same-address ordering: two requesters writing the same register are retired in grant order only. Upstream guarantees it never has two outstanding writes to one register; the hazard unit uses pending to enforce this.
- Pointer wrap: after granting NREQ-1, the search restarts at requester 0.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - Incoming transfers (req_valid && req_ready, addr ≠ 0) join arbitration in the same cycle as the buffered entries, under the same round-robin order.
  - An accepted request that wins skips its buffer and loads the output registers at E0, so the register file writes at E1.
  - Losing incoming requests are buffered as normal.
  - pending also includes a winning bypassed request from E0.
- Undefined: buffers only; latency as in Behaviour.

Decomposition:
- Package rf_ctrl_pkg:
  - constants REG_COUNT = 32, DEF_ADDR_W = 5, DEF_N = 32;
  - typedef wb_req_t {addr, data};
  - function onehot_to_idx.
- Sub-module rr_arbiter (NREQ):
  - input request vector; outputs one-hot grant and grant index.
  - Internal pointer with asynchronous active-low reset, advanced by an "accept" input.

Test Plan:
- Reset: rst = 0 mid-stream with both buffers full → regWrite = 0, pending = 0 and req_ready = all-1 immediately (asynchronous); no write after release.
- Single write: req0 {addr 5, data 0xDEADBEEF} at E0 → regWrite = 1, writeReg = 5, data = 0xDEADBEEF at E1, grant_id = 0; pending[5] high from E0 through E1+1 cycle.
- Contention: req0 {3, 0x11} and req1 {7, 0x22} accepted together → writes addr 3, then addr 7 on consecutive cycles. Repeat: next pair starts with req1 (round robin).
- x0 drop: req1 {addr 0, data 0xFFFF} → handshake completes, regWrite stays 0, pending = 0.
- Back-to-back single requester: req0 valid every cycle with addrs 1, 2, 3 → req_ready toggles 1/0; writes issued every other cycle in order 1, 2, 3.
- RF_WB_BYPASS_EN: idle arbiter, req1 {9, 0xA5A5A5A5} at E0 → regWrite = 1, writeReg = 9 visible after E0; buffer 1 never becomes valid.
